// File: rtl/l2_loss_accumulator_if.sv
// Handshake bundle for l2_loss_accumulator: batch control, per-tile input stream and result port.
// slave = accumulator side, master = producer/consumer side.
interface l2_loss_accumulator_if #(
  parameter int DW = 20,
  parameter int CW = 9,
  parameter int AW = 29
);
  logic          start;
  logic [CW-1:0] num_tiles;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_sum;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_total;
  logic [DW-1:0] out_mean;
  logic          busy;

  modport slave (
    input  start, num_tiles, in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_total, out_mean, busy
  );

  modport master (
    output start, num_tiles, in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_total, out_mean, busy
  );
endinterface

// File: rtl/l2_loss_accumulator.sv
// Sums num_tiles signed L2 partials, then restoring-divides for the mean; latency AW+1 from last input (AW+2 with L2ACC_ROUND_EN).
// in_ready only in ACCUM; result held in DONE until out_ready. L2ACC_ROUND_EN selects round-half-away-from-zero.
module l2_loss_accumulator #(
  parameter int IL        = 4,
  parameter int FL        = 16,
  parameter int MAX_TILES = 256
) (
  input  logic             clk,
  input  logic             reset,
  l2_loss_accumulator_if.slave bus
);
  localparam int DW = IL + FL;
  localparam int CW = $clog2(MAX_TILES + 1);
  localparam int AW = DW + CW;
`ifdef L2ACC_ROUND_EN
  localparam int NW = AW + 1;
`else
  localparam int NW = AW;
`endif
  localparam int SW = $clog2(NW + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DIVIDE, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nx;
  logic signed [AW-1:0] r_acc;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        r_num;
  logic [NW-1:0]        r_dvd;
  logic [CW-1:0]        r_rem;
  logic [SW-1:0]        r_step;
  logic                 r_neg;
  logic [AW-1:0]        r_total;
  logic [DW-1:0]        r_mean;

  logic                 w_hs;
  logic                 w_last;
  logic signed [AW-1:0] w_acc_nx;
  logic [AW-1:0]        w_mag;
  logic [NW-1:0]        w_dvd_init;
  logic [CW:0]          w_rem_sh;
  logic [CW:0]          w_rem_sub;
  logic                 w_ge;
  logic [CW-1:0]        w_rem_nx;
  logic [NW-1:0]        w_quo_nx;
  logic                 w_div_last;
  logic [DW-1:0]        w_mean_mag;
  logic [DW-1:0]        w_mean;

  assign w_hs     = bus.in_valid && (r_state == S_ACCUM);
  assign w_last   = w_hs && (r_cnt == r_num - 1'b1);
  assign w_acc_nx = r_acc + {{CW{bus.in_sum[DW-1]}}, bus.in_sum};
  assign w_mag    = w_acc_nx[AW-1] ? (~w_acc_nx + 1'b1) : w_acc_nx;

  // Dividend is loaded from the final sum on the last handshake so DIVIDE starts stepping immediately.
`ifdef L2ACC_ROUND_EN
  assign w_dvd_init = NW'(w_mag) + NW'(r_num >> 1);
`else
  assign w_dvd_init = w_mag;
`endif

  // One restoring step: dividend/quotient share r_dvd, quotient bits shift in at the LSB.
  assign w_rem_sh   = {r_rem, r_dvd[NW-1]};
  assign w_rem_sub  = w_rem_sh - {1'b0, r_num};
  assign w_ge       = (w_rem_sh >= {1'b0, r_num});
  assign w_rem_nx   = w_ge ? w_rem_sub[CW-1:0] : w_rem_sh[CW-1:0];
  assign w_quo_nx   = {r_dvd[NW-2:0], w_ge};
  assign w_div_last = (r_step == SW'(NW - 1));

  // |mean| never exceeds max |in_sum|, so the low DW quotient bits hold the whole result.
  assign w_mean_mag = w_quo_nx[DW-1:0];
  assign w_mean     = r_neg ? (~w_mean_mag + 1'b1) : w_mean_mag;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nx = (bus.num_tiles != '0) ? S_ACCUM : S_DONE;
        end
      end
      S_ACCUM: begin
        if (w_last) begin
          w_state_nx = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        if (w_div_last) begin
          w_state_nx = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    unique case (r_state)
      S_IDLE:   bus.busy      = 1'b0;
      S_ACCUM:  bus.in_ready  = 1'b1;
      S_DIVIDE: bus.in_ready  = 1'b0;
      S_DONE:   bus.out_valid = 1'b1;
      default:  bus.busy      = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_num   <= '0;
      r_dvd   <= '0;
      r_rem   <= '0;
      r_step  <= '0;
      r_neg   <= 1'b0;
      r_total <= '0;
      r_mean  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_num <= bus.num_tiles;
            r_acc <= '0;
            r_cnt <= '0;
            if (bus.num_tiles == '0) begin
              r_total <= '0;
              r_mean  <= '0;
            end
          end
        end
        S_ACCUM: begin
          if (w_hs) begin
            r_acc <= w_acc_nx;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_dvd  <= w_dvd_init;
              r_rem  <= '0;
              r_step <= '0;
              r_neg  <= w_acc_nx[AW-1];
            end
          end
        end
        S_DIVIDE: begin
          r_dvd  <= w_quo_nx;
          r_rem  <= w_rem_nx;
          r_step <= r_step + 1'b1;
          if (w_div_last) begin
            r_total <= r_acc;
            r_mean  <= w_mean;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_total = r_total;
  assign bus.out_mean  = r_mean;
endmodule

// File: tb/tb_l2_loss_accumulator.sv
// Directed bench for l2_loss_accumulator: stimulus pushes expected results, a monitor pops and checks them.
`timescale 1ns/1ps
module tb_l2_loss_accumulator;
  localparam int IL        = 4;
  localparam int FL        = 16;
  localparam int MAX_TILES = 256;
  localparam int DW        = IL + FL;
  localparam int CW        = $clog2(MAX_TILES + 1);
  localparam int AW        = DW + CW;
`ifdef L2ACC_ROUND_EN
  localparam int LAT = AW + 2;
  localparam bit RND = 1'b1;
`else
  localparam int LAT = AW + 1;
  localparam bit RND = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  l2_loss_accumulator_if #(.DW(DW), .CW(CW), .AW(AW)) bus ();

  l2_loss_accumulator #(.IL(IL), .FL(FL), .MAX_TILES(MAX_TILES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [AW-1:0] total;
    logic [DW-1:0] mean;
    int            vcyc;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];
  exp_t cur;
  bit   have_cur = 1'b0;
  bit   prev_vld = 1'b0;
  logic signed [DW-1:0] vec[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop on the rising edge of out_valid, then hold the DUT to that entry while valid stays up.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_vld = 1'b0;
        have_cur = 1'b0;
      end else begin
        if (bus.out_valid && !prev_vld) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            have_cur = 1'b0;
            $display("FAIL unexpected_result total=0x%0h mean=0x%0h", bus.out_total, bus.out_mean);
          end else begin
            cur      = sb.pop_front();
            have_cur = 1'b1;
            chk("latency_cycle", cyc, cur.vcyc);
          end
        end
        if (bus.out_valid && have_cur) begin
          chk("out_total", bus.out_total, cur.total);
          chk("out_mean", bus.out_mean, cur.mean);
          chk("in_ready_in_done", bus.in_ready, 1'b0);
        end
        prev_vld = bus.out_valid;
      end
    end
  end

  task automatic start_batch(input int n);
    bus.start     = 1'b1;
    bus.num_tiles = CW'(n);
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] v, input int gap, output int hs);
    int n;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sum   = v;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout got 0 want 1");
    end
    hs = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout got busy=%0d pending=%0d want 0", bus.busy, sb.size());
    end
    @(negedge clk);
  endtask

  task automatic run_batch(input int gap, input longint tot, input longint m_trunc, input longint m_round);
    int hs;
    hs = 0;
    start_batch(vec.size());
    foreach (vec[i]) send(vec[i], gap, hs);
    sb.push_back('{AW'(tot), DW'(RND ? m_round : m_trunc), hs + LAT});
    wait_idle();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1'b0);
    chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_out_total"}, bus.out_total, '0);
    chk({tag, "_out_mean"}, bus.out_mean, '0);
  endtask

  initial begin
    int hs;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.num_tiles = '0;
    bus.in_valid  = 1'b0;
    bus.in_sum    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // 1: exact mean 2.5
    vec = {DW'(20'h10000), DW'(20'h20000), DW'(20'h30000), DW'(20'h40000)};
    run_batch(0, 64'hA0000, 64'h28000, 64'h28000);

    // Reset in ACCUM clears the previous batch's results and aborts this one
    start_batch(4);
    chk("accum_busy", bus.busy, 1'b1);
    chk("accum_in_ready", bus.in_ready, 1'b1);
    send(DW'(20'h10000), 0, hs);
    send(DW'(20'h20000), 0, hs);
    reset = 1'b1;
    @(negedge clk);
    chk_zero_outputs("rst_accum");
    reset = 1'b0;
    @(negedge clk);

    vec = {DW'(20'h10000), DW'(20'h20000), DW'(20'h30000), DW'(20'h40000)};
    run_batch(1, 64'hA0000, 64'h28000, 64'h28000);

    // Reset in DIVIDE: no result may appear
    start_batch(2);
    send(DW'(1), 0, hs);
    send(DW'(1), 0, hs);
    repeat (5) @(negedge clk);
    chk("divide_busy", bus.busy, 1'b1);
    chk("divide_in_ready", bus.in_ready, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk_zero_outputs("rst_divide");
    reset = 1'b0;
    @(negedge clk);

    // 2 and 3: truncation vs rounding, positive and negative
    vec = {DW'(1), DW'(2), DW'(2)};
    run_batch(0, 5, 1, 2);
    vec = {DW'(-3), DW'(0)};
    run_batch(0, -3, -1, -2);

    // 4: idle in_valid ignored, gaps, start mid-batch, in_valid during DIVIDE, out_ready stalled
    bus.in_valid = 1'b1;
    bus.in_sum   = DW'(20'h00055);
    repeat (3) @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    start_batch(3);
    send(DW'(20'h00100), 2, hs);
    bus.start     = 1'b1;
    bus.num_tiles = CW'(1);
    @(negedge clk);
    bus.start     = 1'b0;
    send(DW'(-64), 3, hs);
    send(DW'(7), 1, hs);
    sb.push_back('{AW'(199), DW'(66), hs + LAT});
    bus.in_valid = 1'b1;
    bus.in_sum   = DW'(20'h01234);
    repeat (5) @(negedge clk);
    bus.in_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!bus.out_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("stall_reached_done", bus.out_valid, 1'b1);
    end
    repeat (4) @(negedge clk);
    bus.start     = 1'b1;
    bus.num_tiles = CW'(2);
    @(negedge clk);
    bus.start     = 1'b0;
    repeat (5) @(negedge clk);
    chk("stall_still_valid", bus.out_valid, 1'b1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_out_valid", bus.out_valid, 1'b0);
    chk("release_busy", bus.busy, 1'b0);
    chk("hold_out_total", bus.out_total, AW'(199));
    chk("hold_out_mean", bus.out_mean, DW'(66));
    chk("stall_sb_empty", sb.size(), 0);

    // 5: empty batch completes in one cycle with zero results
    sb.push_back('{AW'(0), DW'(0), cyc + 1});
    start_batch(0);
    wait_idle();

    // 6: full-scale batch at MAX_TILES, then most-negative inputs
    vec.delete();
    for (int i = 0; i < MAX_TILES; i++) vec.push_back(DW'(20'h7FFFF));
    run_batch(0, 64'h7FFFF00, 64'h7FFFF, 64'h7FFFF);
    vec = {DW'(-524288), DW'(-524288)};
    run_batch(0, -1048576, -524288, -524288);

    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
